writeback_64: RTL

Write-back stage and architectural register file for the 64-bit Y86 SEQ processor. It sits directly downstream of the memory stage: it takes the executed value (valE), the memory stage's loaded value (valM) and the instruction fields, then commits them to the 15 program registers at the clock edge. It also provides the two combinational read ports used by decode, tracks processor status (run/halt/fault) and counts retired instructions.

---
 rtl/writeback_64_if.sv | 30 +++
 rtl/writeback_64.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/writeback_64_if.sv
// Interface bundle for the writeback_64 stage: retirement inputs, decode
// read ports and architectural status outputs. The master side is the
// pipeline (or bench) driving retirements; the slave side is writeback_64.
interface writeback_64_if;
    logic        valid_in;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [2:0]  stat_in;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;

    modport master (
        output valid_in, icode, cnd, rA, rB, valE, valM, stat_in, srcA, srcB,
        input  valA, valB, stat, halted, retired
    );

    modport slave (
        input  valid_in, icode, cnd, rA, rB, valE, valM, stat_in, srcA, srcB,
        output valA, valB, stat, halted, retired
    );
endinterface

// File: rtl/writeback_64.sv
// Y86-64 SEQ write-back stage with the 15-entry architectural register file,
// two combinational decode read ports, run/halt/fault status tracking and a
// retired-instruction counter.
// Optional feature: define WB_BYPASS_EN to make the read ports write-through
// (a commit pending at the next edge is forwarded, valM before valE).
module writeback_64 (
    input  logic            clk,
    input  logic            rst,
    writeback_64_if.slave   wb
);

    localparam logic [3:0] REG_NONE  = 4'hF;
    localparam logic [3:0] REG_RSP   = 4'h4;

    localparam logic [3:0] IC_RRMOVQ = 4'h2;
    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_OPQ    = 4'h6;
    localparam logic [3:0] IC_CALL   = 4'h8;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_HLT  = 3'd2;
    localparam logic [2:0] STAT_ADR  = 3'd3;
    localparam logic [2:0] STAT_INS  = 3'd4;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_stat;
    logic        r_halted;
    logic [63:0] r_retired;
    logic [63:0] r_regs [15];

    logic [3:0]  w_dst_e;
    logic [3:0]  w_dst_m;
    logic [2:0]  w_stat_norm;
    logic        w_commit;
    logic [63:0] w_val_a;
    logic [63:0] w_val_b;

    // Destination register decode from the retiring instruction's fields.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_dst_e = REG_NONE;
        w_dst_m = REG_NONE;
        unique case (wb.icode)
            IC_OPQ, IC_IRMOVQ:                  w_dst_e = wb.rB;
            IC_RRMOVQ:                          w_dst_e = wb.cnd ? wb.rB : REG_NONE;
            IC_PUSHQ, IC_POPQ, IC_CALL, IC_RET: w_dst_e = REG_RSP;
            default:                            w_dst_e = REG_NONE;
        endcase
        if (wb.icode == IC_MRMOVQ || wb.icode == IC_POPQ) begin
            w_dst_m = wb.rA;
        end
    end

    // Fold undefined upstream status codes onto INS; a commit happens only for AOK in RUN.
    always_comb begin
        w_stat_norm = STAT_INS;
        if (wb.stat_in == STAT_AOK || wb.stat_in == STAT_HLT ||
            wb.stat_in == STAT_ADR || wb.stat_in == STAT_INS) begin
            w_stat_norm = wb.stat_in;
        end
        w_commit = !rst && (r_state == S_RUN) && wb.valid_in && (w_stat_norm == STAT_AOK);
    end

    // Register file commit; the valM write comes last so it wins on a shared destination (popq %rsp).
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is architecturally zeroed on reset, so it is a flop array rather than a RAM macro.
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            // NOTE: non-blocking writes here take effect together at the edge; the second write to the same entry overrides the first.
            if (w_dst_e != REG_NONE) begin
                r_regs[w_dst_e] <= wb.valE;
            end
            if (w_dst_m != REG_NONE) begin
                r_regs[w_dst_m] <= wb.valM;
            end
        end
    end

    // Status state machine with registered stat, halted and retired-count outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_stat    <= STAT_AOK;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (wb.valid_in) begin
                        if (w_stat_norm == STAT_AOK) begin
                            r_retired <= r_retired + 64'd1;
                        end else if (w_stat_norm == STAT_HLT) begin
                            r_retired <= r_retired + 64'd1;
                            r_stat    <= STAT_HLT;
                            r_halted  <= 1'b1;
                            r_state   <= S_HALTED;
                        end else begin
                            r_stat    <= w_stat_norm;
                            r_halted  <= 1'b1;
                            r_state   <= S_FAULT;
                        end
                    end
                end
                S_HALTED, S_FAULT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    // Decode read ports: stored contents, optionally forwarding the pending commit.
    always_comb begin
        w_val_a = '0;
        w_val_b = '0;
        if (wb.srcA != REG_NONE) begin
            w_val_a = r_regs[wb.srcA];
        end
        if (wb.srcB != REG_NONE) begin
            w_val_b = r_regs[wb.srcB];
        end
`ifdef WB_BYPASS_EN
        if (w_commit && wb.srcA != REG_NONE) begin
            if (wb.srcA == w_dst_m) begin
                w_val_a = wb.valM;
            end else if (wb.srcA == w_dst_e) begin
                w_val_a = wb.valE;
            end
        end
        if (w_commit && wb.srcB != REG_NONE) begin
            if (wb.srcB == w_dst_m) begin
                w_val_b = wb.valM;
            end else if (wb.srcB == w_dst_e) begin
                w_val_b = wb.valE;
            end
        end
`endif
    end

    assign wb.valA    = w_val_a;
    assign wb.valB    = w_val_b;
    assign wb.stat    = r_stat;
    assign wb.halted  = r_halted;
    assign wb.retired = r_retired;

endmodule
